// File: rtl/kuznechik_pkg.sv
// Shared types, widths and GF(2^8) helpers for the Kuznechik scheduler slice.
package kuznechik_pkg;

    localparam int BLOCK_W    = 128;
    localparam int KEY_W      = 256;
    localparam int ROUNDS_DEF = 10;
    localparam int NUM_KEYS   = 10;
    // Feistel steps of the key schedule: four groups of eight.
    localparam int KE_STEPS   = 32;

    typedef enum logic [2:0] {
        IDLE,
        KE_START,
        KE_WAIT,
        READY,
        ROUND,
        FINAL,
        HOLD
    } state_t;

    // Nonlinear substitution pi, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };

    // Linear-map coefficients, byte k multiplies input byte a_k.
    localparam logic [127:0] L_COEF = 128'h94208510C2C001FB01C0C21085209401;

    // Multiply in GF(2^8) modulo x^8 + x^7 + x^6 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] a);
        logic [BLOCK_W-1:0] r;
        int idx;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            idx = 2047 - 8 * int'(a[8*k +: 8]);
            r[8*k +: 8] = SBOX[idx -: 8];
        end
        return r;
    endfunction

    // Sixteen passes of the byte-shift register R.
    function automatic logic [BLOCK_W-1:0] l_layer(input logic [BLOCK_W-1:0] a);
        logic [BLOCK_W-1:0] r;
        logic [7:0]         acc;
        r = a;
        for (int n = 0; n < 16; n++) begin
            acc = '0;
            for (int k = 0; k < 16; k++) begin
                acc ^= gf_mul(r[8*k +: 8], L_COEF[8*k +: 8]);
            end
            r = {acc, r[BLOCK_W-1:8]};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_calculation.sv
// Iterative Kuznechik key schedule: one Feistel step per enabled cycle.
module key_calculation
    import kuznechik_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [KEY_W-1:0]   key,
    output logic               finish,
    output logic [BLOCK_W-1:0] round_keys [NUM_KEYS]
);

    logic [5:0]         step;
    logic [5:0]         step_id;
    logic [BLOCK_W-1:0] a1;
    logic [BLOCK_W-1:0] a0;
    logic [BLOCK_W-1:0] round_const;
    logic [BLOCK_W-1:0] next_a1;
    logic [BLOCK_W-1:0] derived [NUM_KEYS-2];

    // Feistel step: round constant C_i = L(i), new left half = LSX(a1 ^ C_i) ^ a0.
    always_comb begin
        step_id     = step + 6'd1;
        round_const = l_layer({{(BLOCK_W-6){1'b0}}, step_id});
        next_a1     = l_layer(s_layer(a1 ^ round_const)) ^ a0;
    end

    // Step counter and Feistel halves; every eighth step yields a key pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= '0;
            a1   <= '0;
            a0   <= '0;
            // NOTE: a reset branch only clears what it names, so arrays need an explicit loop.
            for (int i = 0; i < NUM_KEYS - 2; i++) derived[i] <= '0;
        end else if (!enable) begin
            step <= '0;
            a1   <= key[KEY_W-1 -: BLOCK_W];
            a0   <= key[BLOCK_W-1:0];
        end else if (step != 6'(KE_STEPS)) begin
            step <= step + 6'd1;
            a1   <= next_a1;
            // NOTE: non-blocking, so a0 takes the pre-edge a1 and the halves swap correctly.
            a0   <= a1;
            if (step[2:0] == 3'd7) begin
                derived[{step[4:3], 1'b0}] <= next_a1;
                derived[{step[4:3], 1'b1}] <= a1;
            end
        end
    end

    // K1/K2 come straight from the master key, K3..K10 from the schedule.
    always_comb begin
        finish        = enable && (step == 6'(KE_STEPS));
        round_keys[0] = key[KEY_W-1 -: BLOCK_W];
        round_keys[1] = key[BLOCK_W-1:0];
        for (int i = 0; i < NUM_KEYS - 2; i++) round_keys[i+2] = derived[i];
    end

endmodule

// File: rtl/kuznechik_scheduler.sv
// Kuznechik encryption scheduler: key expansion control, round sequencing, result hold.
module kuznechik_scheduler
    import kuznechik_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEF,
    parameter int KE_TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [KEY_W-1:0]   key,
    output logic               key_ready,
    input  logic               data_valid,
    input  logic [BLOCK_W-1:0] data_in,
    output logic               data_ready,
    output logic               result_valid,
    output logic [BLOCK_W-1:0] result,
    input  logic               result_ready,
    output logic [BLOCK_W-1:0] lsx_in,
    input  logic [BLOCK_W-1:0] lsx_out,
    output logic               keys_loaded,
    output logic               key_error
);

    localparam int                  KE_CNT_W   = $clog2(KE_TIMEOUT + 1);
    localparam logic [3:0]          LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [KE_CNT_W-1:0] KE_LAST    = KE_CNT_W'(KE_TIMEOUT - 1);

    state_t              state;
    state_t              next_state;
    logic [KEY_W-1:0]    key_reg;
    logic [BLOCK_W-1:0]  data_state;
    logic [3:0]          cnt;
    logic [KE_CNT_W-1:0] ke_cnt;
    logic [BLOCK_W-1:0]  rk [ROUNDS];
    logic [BLOCK_W-1:0]  ke_keys [NUM_KEYS];
    logic                ke_enable;
    logic                ke_finish;
    logic                key_accept;
    logic                data_accept;
    logic                ke_done;
    logic                ke_timeout;

    key_calculation u_key_calculation (
        .clk        (clk),
        .rst        (rst),
        .enable     (ke_enable),
        .key        (key_reg),
        .finish     (ke_finish),
        .round_keys (ke_keys)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic, handshakes, key-schedule enable and LSX operand.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned (no latch).
        next_state  = state;
        key_ready   = 1'b0;
        data_ready  = 1'b0;
        ke_enable   = 1'b0;
        lsx_in      = '0;
        key_accept  = 1'b0;
        data_accept = 1'b0;
        ke_done     = 1'b0;
        ke_timeout  = 1'b0;
        unique case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    key_accept = 1'b1;
                    next_state = KE_START;
                end
            end
            KE_START: next_state = KE_WAIT;
            KE_WAIT: begin
                ke_enable = 1'b1;
                if (ke_finish) begin
                    ke_done    = 1'b1;
                    next_state = READY;
                end else if (ke_cnt == KE_LAST) begin
                    ke_timeout = 1'b1;
                    next_state = IDLE;
                end
            end
            READY: begin
                key_ready  = 1'b1;
                data_ready = !key_valid;
                if (key_valid) begin
                    key_accept = 1'b1;
                    next_state = KE_START;
                end else if (data_valid) begin
                    data_accept = 1'b1;
                    next_state  = ROUND;
                end
            end
            ROUND: begin
                lsx_in = data_state ^ rk[cnt - 4'd1];
                if (cnt == LAST_ROUND) next_state = FINAL;
            end
            FINAL:   next_state = HOLD;
            HOLD:    if (result_ready) next_state = READY;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: key capture, round-key store, round state, result and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg      <= '0;
            data_state   <= '0;
            cnt          <= '0;
            ke_cnt       <= '0;
            keys_loaded  <= 1'b0;
            key_error    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) rk[i] <= '0;
        end else begin
            key_error <= ke_timeout;
            ke_cnt    <= (state == KE_WAIT) ? ke_cnt + 1'b1 : '0;
            if (key_accept) begin
                key_reg     <= key;
                keys_loaded <= 1'b0;
            end
            if (ke_done) begin
                for (int i = 0; i < ROUNDS; i++) rk[i] <= ke_keys[i];
                keys_loaded <= 1'b1;
            end else if (ke_timeout) begin
                keys_loaded <= 1'b0;
            end
            if (data_accept) begin
                data_state <= data_in;
                cnt        <= 4'd1;
            end else if (state == ROUND) begin
                data_state <= lsx_out;
                cnt        <= cnt + 4'd1;
            end
            if (state == FINAL) begin
                result       <= data_state ^ rk[ROUNDS-1];
                result_valid <= 1'b1;
            end else if (state == HOLD && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kuznechik_scheduler.sv
// Directed bench for kuznechik_scheduler using the GOST R 34.12-2015 test vector.
module tb_kuznechik_scheduler;

    localparam logic [255:0] KEY = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] PT  = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT  = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] K1  = 128'h8899aabbccddeeff0011223344556677;
    localparam logic [127:0] K2  = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] K3  = 128'hdb31485315694343228d6aef8cc78c44;
    localparam logic [127:0] K10 = 128'h72e9dd7416bcf45b755dbaa88e4a4043;
    localparam logic [127:0] X1  = 128'h99bb99ff99bb99ffffffffffffffffff;

    localparam logic [2047:0] PI_TAB = {
        128'hFCEEDD11CF6E3116FBC4FADA23C5044D, 128'hE977F0DB932E99BA1736F1BB14CD5FC1,
        128'hF918655AE25CEF21811C3C428B018E4F, 128'h058402AEE36A8FA0060BED987FD4D31F,
        128'hEB342C51EAC848ABF22A68A2FD3ACECC, 128'hB5700E56080C7612BF7213479CB75D87,
        128'h15A19629107B9AC7F391786F9D9EB2B1, 128'h3275193DFF358A7E6D54C680C3BD0D57,
        128'hDFF524A93EA843C9D779D6F67C22B903, 128'hE00FECDE7A94B0BCDCE828504E330A4A,
        128'hA79760731E0062441AB83882649F2641, 128'hAD454692275E552F8CA3A57D69D5953B,
        128'h0758B34086AC1DF730376BE488D9E789, 128'hE11B83494C3FF8FE8D53AA90CAD88561,
        128'h207167A42D2B095BCB9B25D0BEE56C52, 128'h59A674D2E6F4B4C0D166AFC2394B63B6
    };
    // l() coefficients for bytes a15 .. a0.
    localparam int LC [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid, data_valid, result_ready;
    logic [255:0] key;
    logic [127:0] data_in;
    logic         key_ready, data_ready, result_valid, keys_loaded, key_error;
    logic [127:0] result, lsx_in, lsx_out;
    logic         key_valid2;
    logic         key_ready2, data_ready2, result_valid2, keys_loaded2, key_error2;
    logic [127:0] result2, lsx_in2, lsx_out2;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic         kv, dv, rr;
        logic         kr, dr, rv, kl;
        logic         chk_res, chk_lsx;
        logic [127:0] lsx;
    } vec_t;

    vec_t tbl [21];

    // Carry-less product then reduction by 0x1C3.
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h1C3 << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [127:0] lsx_model(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   acc;
        for (int j = 0; j < 16; j++) y[127-8*j -: 8] = PI_TAB[2047 - 8*int'(x[127-8*j -: 8]) -: 8];
        for (int n = 0; n < 16; n++) begin
            acc = '0;
            for (int j = 0; j < 16; j++) acc ^= mul(y[127-8*j -: 8], 8'(LC[j]));
            y = {acc, y[127:8]};
        end
        return y;
    endfunction

    function automatic vec_t mk(input logic kv, dv, rr, kr, dr, rv, kl, cres, clsx,
                                input logic [127:0] lsx);
        vec_t v;
        v.kv = kv; v.dv = dv; v.rr = rr; v.kr = kr; v.dr = dr; v.rv = rv; v.kl = kl;
        v.chk_res = cres; v.chk_lsx = clsx; v.lsx = lsx;
        return v;
    endfunction

    assign lsx_out  = lsx_model(lsx_in);
    assign lsx_out2 = lsx_model(lsx_in2);

    always #5 clk = ~clk;

    kuznechik_scheduler dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .key_ready(key_ready),
        .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
        .result_valid(result_valid), .result(result), .result_ready(result_ready),
        .lsx_in(lsx_in), .lsx_out(lsx_out), .keys_loaded(keys_loaded), .key_error(key_error)
    );

    kuznechik_scheduler #(.ROUNDS(10), .KE_TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .key_valid(key_valid2), .key(key), .key_ready(key_ready2),
        .data_valid(1'b0), .data_in(128'h0), .data_ready(data_ready2),
        .result_valid(result_valid2), .result(result2), .result_ready(1'b0),
        .lsx_in(lsx_in2), .lsx_out(lsx_out2), .keys_loaded(keys_loaded2), .key_error(key_error2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        check(name, {127'b0, act}, {127'b0, exp});
    endtask

    task automatic check_reset_values(input string tag);
        chk_bit({tag, " key_ready"}, key_ready, 1'b1);
        chk_bit({tag, " data_ready"}, data_ready, 1'b0);
        chk_bit({tag, " result_valid"}, result_valid, 1'b0);
        check({tag, " result"}, result, 128'h0);
        chk_bit({tag, " keys_loaded"}, keys_loaded, 1'b0);
        chk_bit({tag, " key_error"}, key_error, 1'b0);
        check({tag, " lsx_in"}, lsx_in, 128'h0);
    endtask

    task automatic wait_loaded(input string tag);
        int waited;
        waited = 0;
        while (!keys_loaded && waited < 200) begin
            tick();
            waited++;
        end
        chk_bit({tag, " keys_loaded"}, keys_loaded, 1'b1);
    endtask

    initial begin
        int n;

        // Cycle script from READY with keys loaded: accept, 9 rounds, FINAL, HOLD, re-key.
        tbl[0] = mk(0, 1, 0, 1, 1, 0, 1, 0, 1, 128'h0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, X1);
        for (int i = 2; i <= 9; i++) tbl[i] = mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 128'h0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 128'h0);
        for (int i = 11; i <= 15; i++) tbl[i] = mk(1, 1, 0, 0, 0, 1, 1, 1, 1, 128'h0);
        tbl[16] = mk(0, 0, 1, 0, 0, 1, 1, 1, 1, 128'h0);
        tbl[17] = mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 128'h0);
        tbl[18] = mk(1, 1, 0, 1, 0, 0, 1, 0, 1, 128'h0);
        tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 128'h0);
        tbl[20] = mk(0, 1, 0, 0, 0, 0, 0, 0, 1, 128'h0);

        rst = 1'b1; key_valid = 1'b0; data_valid = 1'b0; result_ready = 1'b0;
        key = KEY; data_in = PT; key_valid2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");
        chk_bit("to reset key_ready", key_ready2, 1'b1);

        // Key-expansion timeout on the KE_TIMEOUT=16 instance.
        key_valid2 = 1'b1;
        tick();
        key_valid2 = 1'b0;
        repeat (16) tick();
        chk_bit("to before key_error", key_error2, 1'b0);
        chk_bit("to waiting key_ready", key_ready2, 1'b0);
        tick();
        chk_bit("to key_error pulse", key_error2, 1'b1);
        chk_bit("to idle key_ready", key_ready2, 1'b1);
        chk_bit("to keys_loaded", keys_loaded2, 1'b0);
        tick();
        chk_bit("to key_error width", key_error2, 1'b0);

        // First key load.
        key_valid = 1'b1;
        #1;
        chk_bit("idle key_ready", key_ready, 1'b1);
        tick();
        key_valid = 1'b0;
        chk_bit("ke_start key_ready", key_ready, 1'b0);
        wait_loaded("load1");
        check("K1 stored", dut.rk[0], K1);
        check("K2 stored", dut.rk[1], K2);
        check("K3 stored", dut.rk[2], K3);
        check("K10 stored", dut.rk[9], K10);

        // Table-driven cycle script.
        for (int i = 0; i < 21; i++) begin
            key_valid = tbl[i].kv; data_valid = tbl[i].dv; result_ready = tbl[i].rr;
            #1;
            chk_bit($sformatf("row%0d key_ready", i), key_ready, tbl[i].kr);
            chk_bit($sformatf("row%0d data_ready", i), data_ready, tbl[i].dr);
            chk_bit($sformatf("row%0d result_valid", i), result_valid, tbl[i].rv);
            chk_bit($sformatf("row%0d keys_loaded", i), keys_loaded, tbl[i].kl);
            if (tbl[i].chk_res) check($sformatf("row%0d result", i), result, CT);
            if (tbl[i].chk_lsx) check($sformatf("row%0d lsx_in", i), lsx_in, tbl[i].lsx);
            tick();
        end
        key_valid = 1'b0; data_valid = 1'b0; result_ready = 1'b0;
        wait_loaded("load2");

        // Reset while in round 5.
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        repeat (4) tick();
        check("round5 lsx_in nonzero", {127'b0, lsx_in == 128'h0}, 128'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midrst");
        check("midrst K1 cleared", dut.rk[0], 128'h0);

        // Re-key and re-encrypt after the reset.
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        wait_loaded("load3");
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        n = 0;
        while (!result_valid && n < 50) begin
            tick();
            n++;
        end
        check("latency", 128'(n), 128'd10);
        check("re-encrypt result", result, CT);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk_bit("release result_valid", result_valid, 1'b0);
        chk_bit("release data_ready", data_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/kuznechik_scheduler.md
KUZNECHIK_SCHEDULER -- requirements
Module: kuznechik_scheduler

Interface
REQ-001 SHALL have parameter ROUNDS, 10, number of round keys; the LSX pass count is ROUNDS-1.
REQ-002 SHALL have parameter KE_TIMEOUT, 1023, maximum cycles to wait for key_calculation finish.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_valid, input, 1, 256-bit key offered.
REQ-006 SHALL have port key, input, 256, master key; key_1 = key[255:128], key_2 = key[127:0].
REQ-007 SHALL have port key_ready, output, 1, key accepted when key_valid && key_ready.
REQ-008 SHALL have port data_valid, input, 1, plaintext block offered.
REQ-009 SHALL have port data_in, input, 128, plaintext block.
REQ-010 SHALL have port data_ready, output, 1, block accepted when data_valid && data_ready.
REQ-011 SHALL have port result_valid, output, 1, ciphertext available.
REQ-012 SHALL have port result, output, 128, ciphertext.
REQ-013 SHALL have port result_ready, input, 1, consumer accepts the result.
REQ-014 SHALL have port lsx_in, output, 128, state XOR current round key, fed to the external L(S(.)) unit.
REQ-015 SHALL have port lsx_out, input, 128, combinational L(S(lsx_in)) return, same cycle.
REQ-016 SHALL have port keys_loaded, output, 1, the round-key store is valid.
REQ-017 SHALL have port key_error, output, 1, one-cycle pulse on key-expansion timeout.

Function
REQ-018 SHALL implement FSM states IDLE, KE_START, KE_WAIT, READY, ROUND, FINAL, HOLD.
REQ-019 SHALL assert key_ready only in IDLE and READY, and SHALL accept the key into the internal 256-bit key register on handshake, then enter KE_START.
REQ-020 SHALL clear keys_loaded on key acceptance, so a new key always invalidates the previous round keys.
REQ-021 SHALL drive key_calculation enable low in IDLE/KE_START (at least 1 cycle), then high throughout KE_WAIT.
REQ-022 SHALL, in KE_WAIT when finish=1, latch key_1..key_10 into a 10x128 round-key store, set keys_loaded=1, drop enable, and enter READY.
REQ-023 SHALL count KE_WAIT cycles; reaching KE_TIMEOUT without finish -> pulse key_error, keys_loaded=0, enable=0, go to IDLE.
REQ-024 SHALL drive data_ready = (state==READY) && !key_valid, giving key_valid priority over data_valid when both are high.
REQ-025 SHALL, on data handshake, load data_in into the state register, clear the round counter to 1, and enter ROUND.
REQ-026 SHALL, in ROUND, drive lsx_in = state XOR K[cnt] and register state <= lsx_out, cnt++; after cnt=ROUNDS-1 go to FINAL.
REQ-027 SHALL, in FINAL, register result = state XOR K[ROUNDS], assert result_valid, and enter HOLD.
REQ-028 SHALL make data-accept to result_valid latency exactly ROUNDS cycles (9 ROUND + 1 FINAL).
REQ-029 SHALL, in HOLD, keep result and result_valid stable until result_ready=1, then return to READY the next cycle; key_ready=data_ready=0 while in HOLD.
REQ-030 SHALL drive lsx_in = 0 outside ROUND.
REQ-031 SHALL make the round counter 4 bits wide; it never wraps because it is bounded by ROUNDS.

Reset
REQ-032 SHALL, with rst=1 at a clock edge, enter IDLE from any state (including mid-KE_WAIT or mid-ROUND).
REQ-033 SHALL reset outputs as: key_ready=1 (from the first cycle after reset), data_ready=0, result_valid=0, result=0, keys_loaded=0, key_error=0, lsx_in=0, key_calculation enable=0.
REQ-034 SHALL reset key register, state register, counters and the round-key store to zero.

Structure
REQ-035 SHALL place the state enum, ROUNDS default, and the 128/256 width constants in shared package kuznechik_pkg.
REQ-036 SHALL instantiate exactly one sub-module, key_calculation, internally; LSX stays external.

Verification
REQ-037 SHALL cover: key 8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef -> keys_loaded=1; stored K1=8899aabbccddeeff0011223344556677, K2=fedcba98765432100123456789abcdef.
REQ-038 SHALL cover: data_in 1122334455667700ffeeddccbbaa9988 with the key above -> result 7f679d90bebc24305a468d42b9d4edcd exactly 10 cycles after the accept.
REQ-039 SHALL cover: result_ready held 0 for 5 cycles -> result stable, data_ready=0; result_ready=1 -> READY next cycle.
REQ-040 SHALL cover: key_valid and data_valid both high in READY -> key accepted, data not accepted, keys_loaded drops to 0.
REQ-041 SHALL cover: finish tied 0, KE_TIMEOUT=16 -> key_error pulse 16 cycles after KE_WAIT entry, state IDLE.
REQ-042 SHALL cover: rst asserted at round 5 -> next cycle all outputs at reset values; re-key and re-encrypt still give 7f679d90bebc24305a468d42b9d4edcd.
